seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the pipeline LED-data selector on the Nexys 4 DDR board.
- Takes the selected 32-bit word (PC/ALU data, cycle, jump, branch or load-use count) and drives the 8-digit common-anode seven-segment display as 8 hex nibbles.
- Time-multiplexes the digits with a programmable refresh prescaler and anti-ghosting blank gap.
- Latches the displayed word once per frame so a counter changing mid-scan never produces torn digits.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz/digit, 125 Hz frame); legal range is ≥ 2 and > GAP.
- GAP, 2, cycles at the start of each digit slot with all anodes off (anti-ghosting).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  32  word to display; nibble k drives digit k (digit 0 is rightmost).
- dp_mask  in  8  decimal-point enables, bit k for digit k, active-high.
- blank_lz  in  1  1 = suppress leading-zero digits.
- an  out  8  anode enables, active-low, one-hot-low or all ones.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame_start  out  1  one-cycle pulse when a new word is latched.

Behaviour:
- State:
  - cnt: prescaler, 0..REFRESH_DIV-1.
  - idx: 3-bit digit index.
  - shadow_data[31:0] and shadow_dp[7:0].
- Reset (rst=0, async, any time including mid-frame):
  - cnt=0, idx=0, shadow_data=0, shadow_dp=0.
  - an=8'hFF, seg=7'h7F, dp=1, frame_start=0.
- tick = (cnt == REFRESH_DIV-1).
  - On tick: cnt←0, idx←idx+1 (7 wraps to 0).
  - Otherwise: cnt←cnt+1.
- Frame latch: on tick with idx==7:
  - shadow_data←data_in, shadow_dp←dp_mask, frame_start←1 for that single cycle.
  - Otherwise frame_start←0.
  - data_in and dp_mask are sampled only at that edge; changes at any other time are invisible.
  - The first frame after reset shows shadow 0 (displays "0", all other digits per blank_lz). The first live value appears after 8·REFRESH_DIV cycles.
- Leading-zero blanking: digit k (k≥1) is blank when blank_lz=1 and shadow_data[31:4k]==0. Digit 0 is never blanked.
- Registered outputs, updated every cycle from the current cnt/idx/shadow, so there is 1-cycle latency:
  - an: 8'hFF if cnt < GAP or the digit is blank; otherwise all ones except bit idx = 0.
  - seg: hex decode of shadow_data[4·idx+3 : 4·idx].
  - dp: ~shadow_dp[idx].
  - seg and dp are driven even while the anode is off.
- Hex decode {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - A data_in change on the same edge as the frame latch: the new value is captured.
  - blank_lz is not latched and takes effect on the next cycle.
- Invariant: at most one an bit is low at any time.

Test Plan (REFRESH_DIV=4, GAP=1):
1. Reset then run 32 cycles with data_in=32'h12345678, blank_lz=0 → an=FF for 1 cycle, then digits 0..7 each low 3 of every 4 cycles, all seg=1000000. frame_start pulses at cycle 32. The next frame shows digit0 seg=0000000 ("8") through digit7 seg=1111001 ("1").
2. Latched frame showing 32'h0000ABCD, change data_in to 32'hFFFFFFFF mid-frame → current frame digits stay D,C,b,A,blank-or-0. The new value appears only after the next frame_start.
3. blank_lz=1 with latched 32'h00000000 → only an[0] ever goes low, seg=1000000. With 32'h00010000 → digits 0..4 lit, an[7:5] stay high.
4. dp_mask=8'h04 latched → dp=0 only during idx=2 slots, 1 elsewhere.
5. Assert rst low asynchronously at idx=5, cnt=2 → an=FF, seg=7F, dp=1 immediately without a clock edge. After release, scan restarts at digit 0 with shadow 0.
6. Random data_in for 10 frames → checker confirms an is never more than one low bit, and the decoded digits equal the nibbles latched at each frame_start.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for the 8-digit seven-segment scan driver.
// The producer (LED-data selector) is the master: it supplies the word, the
// decimal-point mask and the blanking mode, and observes the scan outputs.
interface seg7_scan_driver_if;
    logic [31:0] data_in;
    logic [7:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output data_in,
        output dp_mask,
        output blank_lz,
        input  an,
        input  seg,
        input  dp,
        input  frame_start
    );

    modport slave (
        input  data_in,
        input  dp_mask,
        input  blank_lz,
        output an,
        output seg,
        output dp,
        output frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit owns REFRESH_DIV clock cycles; the first GAP cycles of a slot
// keep every anode off so the previous digit's segments cannot ghost.
// The word is copied into a shadow register once per frame (at the end of
// digit 7), so a value changing during the scan never shows torn digits.
// All display outputs are registered and lag the scan state by one cycle.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP         = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_driver_if.slave    bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP);

    // Scan state
    logic [CNT_W-1:0] cnt_reg,  cnt_next;
    logic [2:0]       idx_reg,  idx_next;
    logic [31:0]      shadow_data_reg, shadow_data_next;
    logic [7:0]       shadow_dp_reg,   shadow_dp_next;

    // Registered display outputs
    logic [7:0]       an_reg,   an_next;
    logic [6:0]       seg_reg,  seg_next;
    logic             dp_reg,   dp_next;
    logic             frame_start_reg, frame_start_next;

    logic             tick;
    logic             frame_latch;
    logic [7:0]       digit_blank;
    logic [3:0]       nibble_cur;

    assign tick        = (cnt_reg == CNT_MAX);
    assign frame_latch = tick && (idx_reg == 3'd7);

    // Digit 0 always shows something, even a lone zero.
    assign digit_blank[0] = 1'b0;

    // Digit k is a leading zero when every nibble from k upward is zero.
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_lz
            assign digit_blank[gi] = bus.blank_lz &&
                                     (shadow_data_reg[31:4*gi] == '0);
        end
    endgenerate

    assign nibble_cur = shadow_data_reg[{idx_reg, 2'b00} +: 4];

    // Prescaler, digit index and once-per-frame shadow capture.
    always_comb begin
        cnt_next         = cnt_reg + 1'b1;
        idx_next         = idx_reg;
        shadow_data_next = shadow_data_reg;
        shadow_dp_next   = shadow_dp_reg;
        frame_start_next = 1'b0;
        if (tick) begin
            cnt_next = '0;
            idx_next = idx_reg + 3'd1;
        end
        if (frame_latch) begin
            shadow_data_next = bus.data_in;
            shadow_dp_next   = bus.dp_mask;
            frame_start_next = 1'b1;
        end
    end

    // Anode select: off during the anti-ghosting gap and for blanked digits.
    always_comb begin
        an_next = 8'hFF;
        if (!(cnt_reg < GAP_C) && !digit_blank[idx_reg]) begin
            an_next = ~(8'd1 << idx_reg);
        end
    end

    // Hex nibble to active-low cathodes {g,f,e,d,c,b,a}.
    always_comb begin
        seg_next = 7'h7F;
        case (nibble_cur)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'h7F;
        endcase
        dp_next = ~shadow_dp_reg[idx_reg];
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg         <= '0;
            idx_reg         <= 3'd0;
            shadow_data_reg <= 32'd0;
            shadow_dp_reg   <= 8'd0;
            an_reg          <= 8'hFF;
            seg_reg         <= 7'h7F;
            dp_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            idx_reg         <= idx_next;
            shadow_data_reg <= shadow_data_next;
            shadow_dp_reg   <= shadow_dp_next;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign bus.an          = an_reg;
    assign bus.seg         = seg_reg;
    assign bus.dp          = dp_reg;
    assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver with REFRESH_DIV=4, GAP=1.
// The reference model derives slot/digit position from the number of clock
// edges since reset and keeps its own copy of the word latched per frame.
module tb_seg7_scan_driver;
    localparam int RDIV = 4;
    localparam int GAPC = 1;
    localparam int FRAME = 8 * RDIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.REFRESH_DIV(RDIV), .GAP(GAPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int          edges = 0;
    logic [31:0] mdl_data = 32'd0;
    logic [7:0]  mdl_dp   = 8'd0;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fs;
    logic [6:0]  hex_tbl [16];

    initial begin
        hex_tbl[0]  = 7'b1000000; hex_tbl[1]  = 7'b1111001;
        hex_tbl[2]  = 7'b0100100; hex_tbl[3]  = 7'b0110000;
        hex_tbl[4]  = 7'b0011001; hex_tbl[5]  = 7'b0010010;
        hex_tbl[6]  = 7'b0000010; hex_tbl[7]  = 7'b1111000;
        hex_tbl[8]  = 7'b0000000; hex_tbl[9]  = 7'b0010000;
        hex_tbl[10] = 7'b0001000; hex_tbl[11] = 7'b0000011;
        hex_tbl[12] = 7'b1000110; hex_tbl[13] = 7'b0100001;
        hex_tbl[14] = 7'b0000110; hex_tbl[15] = 7'b0001110;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Advance one clock: update the model at the edge, compare at the falling edge.
    task automatic step();
        int slot;
        int digit;
        logic [31:0] upper;
        logic blank;
        @(posedge clk);
        if (!rst) begin
            edges    = 0;
            mdl_data = 32'd0;
            mdl_dp   = 8'd0;
            exp_an   = 8'hFF;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
            exp_fs   = 1'b0;
        end else begin
            slot   = edges % RDIV;
            digit  = (edges / RDIV) % 8;
            upper  = mdl_data >> (4 * digit);
            blank  = (digit != 0) && bus.blank_lz && (upper == 32'd0);
            exp_an = (slot < GAPC || blank) ? 8'hFF : ~(8'd1 << digit);
            exp_seg = hex_tbl[upper[3:0]];
            exp_dp  = ~mdl_dp[digit];
            edges   = edges + 1;
            exp_fs  = (edges % FRAME == 0);
            if (exp_fs) begin
                mdl_data = bus.data_in;
                mdl_dp   = bus.dp_mask;
            end
        end
        @(negedge clk);
        check("an", {24'd0, bus.an}, {24'd0, exp_an});
        check("seg", {25'd0, bus.seg}, {25'd0, exp_seg});
        check("dp", {31'd0, bus.dp}, {31'd0, exp_dp});
        check("frame_start", {31'd0, bus.frame_start}, {31'd0, exp_fs});
        check("an_onehot", {31'd0, ($countones(~bus.an) <= 1)}, 32'd1);
        if (exp_fs)
            $display("[TB] frame latched data=%h dp=%h at edge %0d", mdl_data, mdl_dp, edges);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run until the model is at the start of a fresh frame.
    task automatic align_frame();
        int guard = 0;
        while ((edges % FRAME) != 0 && guard < 2 * FRAME) begin
            step();
            guard++;
        end
    endtask

    initial begin
        bus.data_in  = 32'h12345678;
        bus.dp_mask  = 8'h00;
        bus.blank_lz = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b0;
        #1;
        check("rst_an", {24'd0, bus.an}, 32'hFF);
        check("rst_seg", {25'd0, bus.seg}, 32'h7F);
        check("rst_dp", {31'd0, bus.dp}, 32'd1);
        check("rst_fs", {31'd0, bus.frame_start}, 32'd0);
        run(2);
        rst = 1'b1;

        // 1: first frame shows shadow zero, second shows 12345678
        run(2 * FRAME);

        // 2: latch ABCD, then change data mid-frame
        bus.data_in = 32'h0000ABCD;
        align_frame();
        run(FRAME);
        run(12);
        bus.data_in = 32'hFFFFFFFF;
        run(FRAME - 12);
        run(FRAME);

        // 3: leading-zero blanking
        bus.blank_lz = 1'b1;
        bus.data_in  = 32'h00000000;
        run(2 * FRAME);
        bus.data_in  = 32'h00010000;
        run(2 * FRAME);

        // 4: decimal point on digit 2
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 8'h04;
        run(2 * FRAME);

        // 5: asynchronous reset at idx=5, cnt=2
        align_frame();
        run(5 * RDIV + 2);
        #2 rst = 1'b0;
        #1;
        check("arst_an", {24'd0, bus.an}, 32'hFF);
        check("arst_seg", {25'd0, bus.seg}, 32'h7F);
        check("arst_dp", {31'd0, bus.dp}, 32'd1);
        run(2);
        rst = 1'b1;
        run(FRAME);

        // 6: random words, masks and blanking over 10 frames
        for (int f = 0; f < 10; f++) begin
            bus.blank_lz = 1'($urandom_range(0, 1));
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    bus.data_in = $urandom;
                    if ($urandom_range(0, 1) == 1)
                        bus.data_in = bus.data_in >> (4 * $urandom_range(0, 7));
                end
                if ($urandom_range(0, 15) == 0)
                    bus.dp_mask = 8'($urandom);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
